// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control unit
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  // addi x0, x0, 0 - the instruction loaded into IF/ID on a flush
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// rtl/pipeline_control_unit_if.sv - hazard inputs and pipeline control outputs
interface pipeline_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             id_is_halt;
  logic             ex_mispredict;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             is_halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
           id_is_halt, ex_mispredict, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           is_halted, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
           id_is_halt, ex_mispredict, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           is_halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  output logic       lu
);
  // x0 never carries a dependency, so a load into x0 is harmless
  assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
               (id_use_rs2 && (id_rs2 == id_ex_rd)));
endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush/halt sequencer for the 5-stage pipeline
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_control_unit_if.slave  bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  pipe_state_t      state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu;
  logic             stall_inc, flush_inc;

  load_use_detect u_lu (
    .id_rs1         (bus.id_rs1),
    .id_rs2         (bus.id_rs2),
    .id_use_rs1     (bus.id_use_rs1),
    .id_use_rs2     (bus.id_use_rs2),
    .id_ex_rd       (bus.id_ex_rd),
    .id_ex_mem_read (bus.id_ex_mem_read),
    .lu             (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
      if (stall_inc) stall_q <= stall_q + 1'b1;
      if (flush_inc) flush_q <= flush_q + 1'b1;
    end
  end

  // Next state, drain countdown and counter increments
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_busy)           stall_inc = 1'b1;
        else if (bus.ex_mispredict) flush_inc = 1'b1;
        else if (lu)                stall_inc = 1'b1;
        else if (bus.id_is_halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (bus.mem_busy)          stall_inc = 1'b1;
        else if (drain_q == '0)    state_d   = HALTED;
        else                       drain_d   = drain_q - 1'b1;
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  // Control outputs; zero latency from the hazard inputs
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.pipe_freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_busy) begin
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          bus.pipe_freeze = 1'b1;
        end else if (bus.ex_mispredict) begin
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
        end else if (lu) begin
          bus.pc_write     = 1'b0;
          bus.if_id_write  = 1'b0;
          bus.id_ex_bubble = 1'b1;
        end else if (bus.id_is_halt) begin
          bus.pc_write    = 1'b0;
          bus.if_id_flush = 1'b1;
        end
      end
      DRAIN: begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.if_id_flush = 1'b1;
        bus.pipe_freeze = bus.mem_busy;
      end
      HALTED: begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.pipe_freeze = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.is_halted    = halted_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - directed self-checking bench for pipeline_control_unit
module tb_pipeline_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(32)) bus ();

  pipeline_control_unit #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_ex_rd = 5'd0; bus.id_ex_mem_read = 1'b0;
    bus.id_is_halt = 1'b0; bus.ex_mispredict = 1'b0; bus.mem_busy = 1'b0;
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = rd;
    bus.id_rs1 = rs1; bus.id_use_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_use_rs2 = u2;
    #1;
  endtask

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  function automatic logic [4:0] ctl();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_freeze};
  endfunction

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_halted"}, 32'(bus.is_halted), 32'd0);
    chk({tag, "_stall"}, bus.stall_cycles, 32'd0);
    chk({tag, "_flush"}, bus.flush_count, 32'd0);
    chk({tag, "_ctl"}, 32'(ctl()), 32'b11000);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    clear_in();
    #3;
    chk("rst_ctl", 32'(ctl()), 32'b11000);
    chk("rst_halted", 32'(bus.is_halted), 32'd0);
    chk("rst_stall", bus.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // load-use via rs1
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk("lu_rs1_ctl", 32'(ctl()), 32'b00010);
    tick(); clear_in();
    chk("lu_rs1_stall", bus.stall_cycles, 32'd1);
    chk("lu_after_ctl", 32'(ctl()), 32'b11000);
    // load into x0: no stall
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    chk("lu_x0_ctl", 32'(ctl()), 32'b11000);
    tick(); clear_in();
    chk("lu_x0_stall", bus.stall_cycles, 32'd1);
    // rs2 match, rs1 match but unused
    set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    chk("lu_rs2_ctl", 32'(ctl()), 32'b00010);
    tick(); clear_in();
    set_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    chk("lu_unused_ctl", 32'(ctl()), 32'b11000);
    tick(); clear_in();
    chk("lu_rs2_stall", bus.stall_cycles, 32'd2);
    pulse_reset("rst1");

    // mispredict wins over load-use
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    bus.ex_mispredict = 1'b1; #1;
    chk("mp_lu_ctl", 32'(ctl()), 32'b11110);
    tick(); clear_in();
    chk("mp_lu_flush", bus.flush_count, 32'd1);
    chk("mp_lu_stall", bus.stall_cycles, 32'd0);
    pulse_reset("rst2");

    // freeze defers the mispredict for 3 cycles
    bus.mem_busy = 1'b1; bus.ex_mispredict = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz_ctl%0d", i), 32'(ctl()), 32'b00001);
      tick();
    end
    bus.mem_busy = 1'b0; #1;
    chk("frz_release_ctl", 32'(ctl()), 32'b11110);
    tick(); clear_in();
    chk("frz_stall", bus.stall_cycles, 32'd3);
    chk("frz_flush", bus.flush_count, 32'd1);
    pulse_reset("rst3");

    // halt, no freezes: flush on T..T+4, halted from T+5
    bus.id_is_halt = 1'b1; #1;
    chk("halt_T_ctl", 32'(ctl()), 32'b01100);
    tick(); clear_in();
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin bus.ex_mispredict = 1'b1; bus.id_is_halt = 1'b1; #1; end
      chk($sformatf("drain%0d_ctl", i), 32'(ctl()), 32'b00100);
      chk($sformatf("drain%0d_halted", i), 32'(bus.is_halted), 32'd0);
      tick(); clear_in();
    end
    chk("halted_flag", 32'(bus.is_halted), 32'd1);
    chk("halted_ctl", 32'(ctl()), 32'b00001);
    chk("drain_no_flush", bus.flush_count, 32'd0);
    bus.mem_busy = 1'b1; bus.ex_mispredict = 1'b1; #1;
    tick(); tick(); clear_in();
    chk("halted_stall_frozen", bus.stall_cycles, 32'd0);
    chk("halted_sticky", 32'(bus.is_halted), 32'd1);
    pulse_reset("rst_halted");

    // halt with 2 busy cycles inside DRAIN: 6 drain cycles
    bus.id_is_halt = 1'b1; #1;
    tick(); clear_in();
    for (int i = 1; i <= 6; i++) begin
      bus.mem_busy = (i == 2 || i == 3); #1;
      chk($sformatf("bdrain%0d_ctl", i), 32'(ctl()), (i == 2 || i == 3) ? 32'b00101 : 32'b00100);
      chk($sformatf("bdrain%0d_halted", i), 32'(bus.is_halted), 32'd0);
      tick(); clear_in();
    end
    chk("bdrain_halted", 32'(bus.is_halted), 32'd1);
    chk("bdrain_stall", bus.stall_cycles, 32'd2);
    pulse_reset("rst4");

    // reset in the middle of DRAIN
    bus.id_is_halt = 1'b1; #1;
    tick(); clear_in();
    tick();
    chk("mid_drain_ctl", 32'(ctl()), 32'b00100);
    pulse_reset("rst_drain");
    set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    chk("post_rst_lu_ctl", 32'(ctl()), 32'b00010);
    tick(); clear_in();
    chk("post_rst_lu_stall", bus.stall_cycles, 32'd1);
    pulse_reset("rst5");

    // halt held back by a load-use stall
    set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    bus.id_is_halt = 1'b1; #1;
    chk("halt_lu_ctl", 32'(ctl()), 32'b00010);
    tick();
    bus.id_ex_mem_read = 1'b0; #1;
    chk("halt_lu_accept_ctl", 32'(ctl()), 32'b01100);
    tick(); clear_in();
    chk("halt_lu_drain_ctl", 32'(ctl()), 32'b00100);
    tick(); tick(); tick();
    chk("halt_lu_not_yet", 32'(bus.is_halted), 32'd0);
    tick();
    chk("halt_lu_halted", 32'(bus.is_halted), 32'd1);
    pulse_reset("rst6");

    // halt on the wrong path is ignored
    bus.id_is_halt = 1'b1; bus.ex_mispredict = 1'b1; #1;
    chk("halt_mp_ctl", 32'(ctl()), 32'b11110);
    tick(); clear_in();
    chk("halt_mp_run_ctl", 32'(ctl()), 32'b11000);
    chk("halt_mp_flush", bus.flush_count, 32'd1);
    tick();
    chk("halt_mp_not_halted", 32'(bus.is_halted), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
